// File: rtl/div_ctrl.sv
// div_ctrl: sequencer for the iterative restoring divider feeding HI/LO.
//
// A DIV/DIVU in the execute stage is captured when startE is seen in IDLE. The
// divider then runs one restoring step per cycle for WIDTH cycles. It then
// presents the remainder on HI and the quotient on LO for a single DONE cycle.
// The pipeline stall request is held for the start cycle and every BUSY cycle.
//
// Ports
//   clk, resetn        rising-edge clock, asynchronous active-low reset
//   startE             divide present in E (level); sampled only in IDLE
//   signedE            1 = DIV (signed), 0 = DIVU; sampled with startE
//   opaE, opbE         dividend / divisor; sampled with startE
//   cancel             flush/exception; aborts any operation, highest priority
//   stall_div          stall request to the hazard unit (combinational)
//   busy               high while the iteration is running
//   done               one-cycle pulse when hi_o/lo_o are valid
//   hi_o, lo_o         remainder / quotient, meaningful only while done = 1
//   hilo_we_o          2'b11 while done = 1, else 2'b00
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] opaE,
  input  logic [WIDTH-1:0] opbE,
  input  logic             cancel,
  output logic             stall_div,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       hilo_we_o
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;      // partial remainder, one guard bit
  logic [WIDTH-1:0] quo_q, quo_d;      // dividend magnitude shifting into quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh, rem_sub, rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             take;
  logic [WIDTH-1:0] fin_quo, fin_rem;

  // Operand magnitudes and one restoring step.
  always_comb begin
    abs_a    = (signedE && opaE[WIDTH-1]) ? -opaE : opaE;
    abs_b    = (signedE && opbE[WIDTH-1]) ? -opbE : opbE;
    rem_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, dvs_q};
    take     = (rem_sh >= {1'b0, dvs_q});
    rem_step = take ? rem_sub : rem_sh;
    quo_step = {quo_q[WIDTH-2:0], take};
    // Sign fix is applied to the final step's result so HI/LO land together
    // with the BUSY->DONE transition.
    fin_quo  = neg_quo_q ? -quo_step : quo_step;
    fin_rem  = neg_rem_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    if (cancel) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (startE) begin
            state_d   = BUSY;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = abs_a;
            dvs_d     = abs_b;
            neg_quo_d = signedE & (opaE[WIDTH-1] ^ opbE[WIDTH-1]);
            neg_rem_d = signedE & opaE[WIDTH-1];
          end
        end
        BUSY: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            hi_d    = fin_rem;
            lo_d    = fin_quo;
            done_d  = 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // A flush landing on the DONE cycle squashes the HI/LO write, so the
  // registered pulse is qualified with cancel. resetn also masks the stall so
  // that every output is low while reset is held.
  assign busy      = (state_q == BUSY);
  assign stall_div = resetn & ~cancel & (((state_q == IDLE) & startE) | (state_q == BUSY));
  assign done      = done_q & ~cancel;
  assign hilo_we_o = {2{done}};
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
`timescale 1ns/1ps
module tb_div_ctrl;
  localparam int unsigned W     = 32;
  localparam int          BOUND = 100;

  logic         clk = 1'b0;
  logic         resetn, startE, signedE, cancel;
  logic [W-1:0] opaE, opbE, hi_o, lo_o;
  logic         stall_div, busy, done;
  logic [1:0]   hilo_we_o;

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  logic [2*W-1:0] exp_q[$];

  div_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .startE(startE), .signedE(signedE),
    .opaE(opaE), .opbE(opbE), .cancel(cancel), .stall_div(stall_div),
    .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o), .hilo_we_o(hilo_we_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_count++;

  // Reference: {remainder, quotient}.
  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = (s && a[W-1]) ? W'(1) : '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      q = a;
      r = '0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  // Drives one start cycle (T), records the stall seen in T, returns at T+1.
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, output int stall0);
    @(negedge clk);
    startE = 1'b1; signedE = s; opaE = a; opbE = b;
    exp_q.push_back(model(s, a, b));
    #1 stall0 = (stall_div === 1'b1) ? 1 : 0;
    @(negedge clk);
    startE = 1'b0;
  endtask

  // Waits (bounded) for done; cyc is the cycle index relative to T.
  task automatic wait_done(input int start_cyc, output int cyc, output int stalls);
    cyc = start_cyc; stalls = 0;
    #1;
    while (done !== 1'b1 && cyc < BOUND) begin
      if (stall_div === 1'b1) stalls++;
      @(negedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; startE = 1'b0; signedE = 1'b0; cancel = 1'b0; opaE = '0; opbE = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({stall_div, busy, done, hilo_we_o} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {stall_div, busy, done, hilo_we_o}); end
    checks++; if ({hi_o, lo_o} !== '0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi_o, lo_o}); end
    @(negedge clk); resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({stall_div, busy, done} !== 3'b0) begin errors++; $display("FAIL reset_idle: got %b expected 000", {stall_div, busy, done}); end
  endtask

  task automatic test_divu_basic();
    int s0, cyc, st;
    logic [2*W-1:0] e;
    launch(1'b0, 32'd100, 32'd7, s0);
    wait_done(1, cyc, st);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (cyc != 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", cyc); end
    checks++; if (s0 + st != 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d expected 33", s0 + st); end
    checks++; if (lo_o !== 32'd14 || hi_o !== 32'd2) begin errors++; $display("FAIL divu_100_7: got hi=%h lo=%h expected hi=2 lo=e", hi_o, lo_o); end
    checks++; if ({hi_o, lo_o} !== e) begin errors++; $display("FAIL divu_scoreboard: got %h expected %h", {hi_o, lo_o}, e); end
    checks++; if (hilo_we_o !== 2'b11) begin errors++; $display("FAIL divu_we: got %b expected 11", hilo_we_o); end
    checks++; if (stall_div !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL divu_done_stall: got stall=%b busy=%b expected 0 0", stall_div, busy); end
    @(negedge clk); #1;
    checks++; if ({done, hilo_we_o} !== 3'b0) begin errors++; $display("FAIL divu_pulse_width: got %b expected 000", {done, hilo_we_o}); end
  endtask

  task automatic test_signed();
    logic         ts [3] = '{1'b1, 1'b1, 1'b1};
    logic [W-1:0] ta [3] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
    logic [W-1:0] tb [3] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [W-1:0] tl [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3};
    logic [W-1:0] th [3] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    int s0, cyc, st;
    logic [2*W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      launch(ts[i], ta[i], tb[i], s0);
      wait_done(1, cyc, st);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++; if (hi_o !== th[i] || lo_o !== tl[i]) begin errors++; $display("FAIL signed_%0d: got hi=%h lo=%h expected hi=%h lo=%h", i, hi_o, lo_o, th[i], tl[i]); end
      checks++; if ({hi_o, lo_o} !== e) begin errors++; $display("FAIL signed_sb_%0d: got %h expected %h", i, {hi_o, lo_o}, e); end
    end
  endtask

  task automatic test_corner();
    logic         ts [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] ta [3] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFF6};
    logic [W-1:0] tb [3] = '{32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] tl [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
    logic [W-1:0] th [3] = '{32'd5, 32'd0, 32'hFFFF_FFF6};
    int s0, cyc, st;
    logic [2*W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      launch(ts[i], ta[i], tb[i], s0);
      wait_done(1, cyc, st);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++; if (cyc != 33) begin errors++; $display("FAIL corner_latency_%0d: got %0d expected 33", i, cyc); end
      checks++; if (hi_o !== th[i] || lo_o !== tl[i]) begin errors++; $display("FAIL corner_%0d: got hi=%h lo=%h expected hi=%h lo=%h", i, hi_o, lo_o, th[i], tl[i]); end
      checks++; if ({hi_o, lo_o} !== e) begin errors++; $display("FAIL corner_sb_%0d: got %h expected %h", i, {hi_o, lo_o}, e); end
    end
  endtask

  task automatic test_random();
    int s0, cyc, st;
    logic         s;
    logic [W-1:0] a, b;
    logic [2*W-1:0] e;
    for (int i = 0; i < 5; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i < 2) ? W'($urandom_range(1, 300)) : $urandom;
      launch(s, a, b, s0);
      wait_done(1, cyc, st);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++; if ({hi_o, lo_o} !== e || cyc != 33) begin errors++; $display("FAIL random_%0d: s=%b a=%h b=%h got %h at %0d expected %h at 33", i, s, a, b, {hi_o, lo_o}, cyc, e); end
    end
  endtask

  task automatic test_cancel();
    int s0, cyc, st, base;
    logic [2*W-1:0] e;
    launch(1'b0, 32'd100, 32'd7, s0);
    e = exp_q.pop_back();
    base = done_count;
    repeat (9) @(negedge clk);
    cancel = 1'b1; #1;
    checks++; if (stall_div !== 1'b0) begin errors++; $display("FAIL cancel_stall: got %b expected 0", stall_div); end
    @(negedge clk); cancel = 1'b0; #1;
    checks++; if (busy !== 1'b0 || stall_div !== 1'b0) begin errors++; $display("FAIL cancel_idle: got busy=%b stall=%b expected 0 0", busy, stall_div); end
    repeat (40) @(negedge clk);
    #1;
    checks++; if (done_count != base) begin errors++; $display("FAIL cancel_no_done: got %0d pulses expected 0", done_count - base); end
    launch(1'b0, 32'd9, 32'd3, s0);
    wait_done(1, cyc, st);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (lo_o !== 32'd3 || hi_o !== 32'd0 || cyc != 33) begin errors++; $display("FAIL cancel_next: got hi=%h lo=%h at %0d expected hi=0 lo=3 at 33", hi_o, lo_o, cyc); end
    checks++; if ({hi_o, lo_o} !== e) begin errors++; $display("FAIL cancel_next_sb: got %h expected %h", {hi_o, lo_o}, e); end
  endtask

  task automatic test_async_reset();
    int s0, base;
    logic [2*W-1:0] e;
    launch(1'b0, 32'd1000, 32'd3, s0);
    e = exp_q.pop_back();
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++; if ({stall_div, busy, done, hilo_we_o} !== 5'b0) begin errors++; $display("FAIL async_reset_ctrl: got %b expected 00000", {stall_div, busy, done, hilo_we_o}); end
    checks++; if ({hi_o, lo_o} !== '0) begin errors++; $display("FAIL async_reset_hilo: got %h expected 0", {hi_o, lo_o}); end
    base = done_count;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    checks++; if (done_count != base || busy !== 1'b0 || stall_div !== 1'b0) begin errors++; $display("FAIL async_reset_quiet: got pulses=%0d busy=%b stall=%b expected 0 0 0", done_count - base, busy, stall_div); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [2*W-1:0] e;
    @(negedge clk);
    startE = 1'b1; signedE = 1'b0; opaE = 32'd6; opbE = 32'd3;
    exp_q.push_back(model(1'b0, 32'd6, 32'd3));
    cyc = 0; #1;
    while (done !== 1'b1 && cyc < BOUND) begin @(negedge clk); #1; cyc++; end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (cyc != 33 || lo_o !== 32'd2 || {hi_o, lo_o} !== e) begin errors++; $display("FAIL b2b_first: got lo=%h at %0d expected lo=2 at 33", lo_o, cyc); end
    opaE = 32'd8; opbE = 32'd2;
    exp_q.push_back(model(1'b0, 32'd8, 32'd2));
    @(negedge clk); #1; cyc++;
    checks++; if (stall_div !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_start: got stall=%b busy=%b expected 1 0", stall_div, busy); end
    @(negedge clk); startE = 1'b0; #1; cyc++;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    while (done !== 1'b1 && cyc < BOUND) begin @(negedge clk); #1; cyc++; end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (cyc != 67 || lo_o !== 32'd4 || {hi_o, lo_o} !== e) begin errors++; $display("FAIL b2b_second: got lo=%h at %0d expected lo=4 at 67", lo_o, cyc); end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_corner();
    test_random();
    test_cancel();
    test_async_reset();
    test_back_to_back();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d left expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
